// File: rtl/pc_gen_pkg.sv
// Shared encodings for the PC generator with return-address stack.
// Contents: br_mode values selecting how a taken transfer forms the next PC.
// Used by: pc_gen_ras.
package pc_gen_pkg;

  localparam logic [1:0] BR_REL = 2'b00;  // PC-relative, offset in instructions
  localparam logic [1:0] BR_ABS = 2'b01;  // absolute target, aligned
  localparam logic [1:0] BR_RET = 2'b10;  // return through the RAS top entry
  localparam logic [1:0] BR_RSV = 2'b11;  // reserved, behaves as BR_REL

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push writes above top, pop moves top down.
// Ports: clk/resetn; push, pop, wdata in; top, count, full, empty out.
// Push while full overwrites the oldest entry; push+pop replaces the top entry.
module ras_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     top,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_up;
  logic             pop_ok;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CNT_W'(DEPTH));
  assign pop_ok = pop && !empty;
  // DEPTH is a power of two, so pointer arithmetic wraps around the ring.
  assign ptr_up = top_q + PTR_W'(1);

  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    if (push && !pop_ok) begin
      top_d = ptr_up;
      // When full the slot above top is the oldest entry; count saturates.
      if (!full) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_ok && !push) begin
      top_d = top_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      top_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
      if (push && pop_ok) mem_q[top_q]  <= wdata;
      else if (push)      mem_q[ptr_up] <= wdata;
    end
  end

  assign top   = empty ? '0 : mem_q[top_q];
  assign count = cnt_q;

endmodule

// File: rtl/pc_gen_ras.sv
// Fetch PC generator: sequential, PC-relative, absolute and return flow with a RAS.
// Ports: clk/resetn; PC_Wen stall, br/br_mode/link/offset/target controls;
//        PC, LR (RAS top), ras_count, sticky ras_ovf/ras_unf out. Next PC lands 1 clk later.
module pc_gen_ras
  import pc_gen_pkg::*;
#(
  parameter int              ADDR_W    = 16,
  parameter int              OFF_W     = 16,
  parameter int              INSTR_SH  = 1,
  parameter int              RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         PC_Wen,
  input  logic                         br,
  input  logic [1:0]                   br_mode,
  input  logic                         link,
  input  logic [OFF_W-1:0]             offset,
  input  logic [ADDR_W-1:0]            target,
  output logic [ADDR_W-1:0]            PC,
  output logic [ADDR_W-1:0]            LR,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_ovf,
  output logic                         ras_unf
);

  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(1) << INSTR_SH;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STEP - ADDR_W'(1));

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [ADDR_W-1:0] pc_seq, pc_rel, off_ext;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_full, ras_empty;
  logic              is_ret, push, pop;

  assign pc_seq  = pc_q + STEP;
  // Sign-extend (or truncate) the offset to ADDR_W, then scale to bytes.
  assign off_ext = ADDR_W'(signed'(offset));
  assign pc_rel  = pc_q + (off_ext << INSTR_SH) + (STEP << 1);

  assign is_ret = br && (br_mode == BR_RET);
  assign push   = PC_Wen && link;
  assign pop    = PC_Wen && is_ret && !ras_empty;

  ras_stack #(
    .W     (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .wdata  (pc_seq),
    .top    (ras_top),
    .count  (ras_count),
    .full   (ras_full),
    .empty  (ras_empty)
  );

  always_comb begin
    pc_d = pc_seq;
    if (br) begin
      case (br_mode)
        BR_ABS:  pc_d = target & ALIGN_MASK;
        BR_RET:  pc_d = ras_empty ? pc_seq : ras_top;
        default: pc_d = pc_rel;
      endcase
    end
  end

  // Overflow is a push that must drop the oldest entry; a push paired with a
  // pop only replaces the top and never overflows.
  assign ovf_d = ovf_q || (push && !pop && ras_full);
  assign unf_d = unf_q || (PC_Wen && is_ret && ras_empty);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q  <= RESET_PC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (PC_Wen) begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign PC      = pc_q;
  assign LR      = ras_top;
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;

endmodule

// File: tb/tb_pc_gen_ras.sv
module tb_pc_gen_ras;

  logic        clk;
  logic        resetn;
  logic        PC_Wen;
  logic        br;
  logic [1:0]  br_mode;
  logic        link;
  logic [15:0] offset;
  logic [15:0] target;
  logic [15:0] PC;
  logic [15:0] LR;
  logic [2:0]  ras_count;
  logic        ras_ovf;
  logic        ras_unf;

  pc_gen_ras dut (
    .clk       (clk),
    .resetn    (resetn),
    .PC_Wen    (PC_Wen),
    .br        (br),
    .br_mode   (br_mode),
    .link      (link),
    .offset    (offset),
    .target    (target),
    .PC        (PC),
    .LR        (LR),
    .ras_count (ras_count),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  // Behavioural model: PC as an integer, RAS as a queue (back = top).
  logic [15:0] m_pc;
  int          m_ras[$];
  bit          m_ovf, m_unf;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_lr();
    return (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 0;
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000;
    m_ras.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic model_step(input bit wen, input bit b, input logic [1:0] md,
                            input bit lk, input logic [15:0] off, input logic [15:0] tgt);
    int  seq, npc;
    bit  popped;
    if (!wen) return;
    seq    = (int'(m_pc) + 2) % 65536;
    npc    = seq;
    popped = 0;
    if (b) begin
      if (md == 2'd1) npc = int'(tgt) / 2 * 2;
      else if (md == 2'd2) begin
        if (m_ras.size() > 0) begin npc = m_lr(); popped = 1; end
        else m_unf = 1;
      end else npc = (int'(m_pc) + 2 * int'($signed(off)) + 4 + 65536 * 4) % 65536;
    end
    if (popped && lk) m_ras[m_ras.size()-1] = seq;
    else if (popped) void'(m_ras.pop_back());
    else if (lk) begin
      if (m_ras.size() == 4) begin m_ovf = 1; void'(m_ras.pop_front()); end
      m_ras.push_back(seq);
    end
    m_pc = 16'(npc);
  endtask

  // Compare process: every falling edge the outputs must match the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_pc",    int'(PC),        int'(m_pc));
      check("cyc_lr",    int'(LR),        m_lr());
      check("cyc_count", int'(ras_count), m_ras.size());
      check("cyc_ovf",   int'(ras_ovf),   int'(m_ovf));
      check("cyc_unf",   int'(ras_unf),   int'(m_unf));
    end
  end

  // Apply one cycle of controls; returns #1 after the active edge.
  task automatic step(input bit wen, input bit b, input logic [1:0] md,
                      input bit lk, input logic [15:0] off, input logic [15:0] tgt);
    PC_Wen = wen; br = b; br_mode = md; link = lk; offset = off; target = tgt;
    @(posedge clk);
    model_step(wen, b, md, lk, off, tgt);
    #1;
  endtask

  task automatic seq1();  step(1, 0, 2'd0, 0, 16'h0, 16'h0); endtask
  task automatic jabs(input logic [15:0] t); step(1, 1, 2'd1, 0, 16'h0, t); endtask
  task automatic ret(input bit lk); step(1, 1, 2'd2, lk, 16'h0, 16'h0); endtask

  initial begin
    PC_Wen = 0; br = 0; br_mode = 0; link = 0; offset = 0; target = 0;
    resetn = 0;
    model_reset();
    #12;
    check("rst_pc",    int'(PC), 0);
    check("rst_count", int'(ras_count), 0);
    check("rst_lr",    int'(LR), 0);
    @(negedge clk);
    resetn = 1;
    chk_en = 1;

    // 1: sequential flow
    seq1(); check("t1_pc1", int'(PC), 16'h0002);
    seq1(); check("t1_pc2", int'(PC), 16'h0004);
    seq1(); check("t1_pc3", int'(PC), 16'h0006);

    // 2: relative branches, negative and positive offsets
    jabs(16'h0010);
    step(1, 1, 2'd0, 0, 16'hFFFE, 16'h0); check("t2_rel_neg", int'(PC), 16'h0010);
    step(1, 1, 2'd0, 0, 16'h0003, 16'h0); check("t2_rel_pos", int'(PC), 16'h001A);
    step(1, 1, 2'd3, 0, 16'h0001, 16'h0); check("t2_rsv_rel", int'(PC), 16'h0020);

    // 3: call and return
    step(1, 1, 2'd0, 1, 16'h0008, 16'h0);
    check("t3_call_pc", int'(PC), 16'h0034);
    check("t3_call_lr", int'(LR), 16'h0022);
    check("t3_call_cnt", int'(ras_count), 1);
    ret(0);
    check("t3_ret_pc", int'(PC), 16'h0022);
    check("t3_ret_cnt", int'(ras_count), 0);
    check("t3_ret_lr", int'(LR), 0);

    // push+pop: call, then link+return swaps the top entry
    step(1, 1, 2'd0, 1, 16'h0000, 16'h0);   // PC 0x0026, LR 0x0024
    ret(1);
    check("t3_pp_pc",  int'(PC), 16'h0024);
    check("t3_pp_lr",  int'(LR), 16'h0028);
    check("t3_pp_cnt", int'(ras_count), 1);
    ret(0);
    check("t3_pp_ret", int'(PC), 16'h0028);

    // 4: five nested calls overflow a depth-4 stack
    jabs(16'h0100);
    for (int i = 0; i < 5; i++) step(1, 1, 2'd0, 1, 16'h0000, 16'h0);
    check("t4_pc",  int'(PC), 16'h0114);
    check("t4_cnt", int'(ras_count), 4);
    check("t4_ovf", int'(ras_ovf), 1);
    check("t4_unf0", int'(ras_unf), 0);
    ret(0); check("t4_r1", int'(PC), 16'h0112);
    ret(0); check("t4_r2", int'(PC), 16'h010E);
    ret(0); check("t4_r3", int'(PC), 16'h010A);
    ret(0); check("t4_r4", int'(PC), 16'h0106);
    ret(0);
    check("t4_r5_pc",  int'(PC), 16'h0108);
    check("t4_r5_unf", int'(ras_unf), 1);
    // link with an underflowing return acts as a plain push
    ret(1);
    check("t4_ulk_pc",  int'(PC), 16'h010A);
    check("t4_ulk_lr",  int'(LR), 16'h010A);
    check("t4_ulk_cnt", int'(ras_count), 1);
    ret(0);

    // 5: stall, wrap, absolute alignment
    for (int i = 0; i < 3; i++) step(0, 1, 2'd0, 1, 16'h0040, 16'h0);
    check("t5_stall_pc",  int'(PC), 16'h010A);
    check("t5_stall_cnt", int'(ras_count), 0);
    jabs(16'hFFFE);
    seq1(); check("t5_wrap", int'(PC), 16'h0000);
    jabs(16'h1235); check("t5_abs", int'(PC), 16'h1234);

    // 6: asynchronous reset mid-call
    step(1, 1, 2'd0, 1, 16'h0010, 16'h0);
    step(1, 1, 2'd0, 1, 16'h0010, 16'h0);
    check("t6_pre_cnt", int'(ras_count), 2);
    #2;
    resetn = 0;
    model_reset();
    #1;
    check("t6_pc",  int'(PC), 0);
    check("t6_cnt", int'(ras_count), 0);
    check("t6_lr",  int'(LR), 0);
    check("t6_ovf", int'(ras_ovf), 0);
    check("t6_unf", int'(ras_unf), 0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1;
    seq1(); check("t6_after", int'(PC), 16'h0002);
    seq1();
    @(negedge clk);
    chk_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
